// File: rtl/serializer_pkg.sv
// Shared types and constants for the pattern serializer.
// Holds the FSM state enum, default sizing and counter-width helper.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int   DEF_WIDTH      = 8;
  localparam int   CNT_W          = $clog2(DEF_WIDTH);
  localparam logic DEF_IDLE_LEVEL = 1'b0;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo bit counter with clear, enable and terminal-count flag.
// Ports: clock, reset (async low), clr, en -> cnt, tc (cnt==MODULUS-1).
module bit_counter
  import serializer_pkg::*;
#(
  parameter int MODULUS = DEF_WIDTH,
  parameter int W       = cnt_w(MODULUS)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial stage feeding the 1011 detector, one bit per clock.
// Ports: load_valid/load_data/load_ready, abort -> sequence_out, bit_valid, busy, done.
module pattern_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             abort,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             seq_q, seq_d;
  logic             bv_q, bv_d;

  logic [CW-1:0] cnt;
  logic          tc;
  logic          cnt_clr;
  logic          cnt_en;
  logic          accept;
  logic          advance;

  bit_counter #(
    .MODULUS (WIDTH),
    .W       (CW)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign busy       = (state_q == SHIFT);
  assign done       = busy && (cnt == LAST);
  assign load_ready = !abort && (state_q == IDLE || (busy && tc));
  assign accept     = load_valid && load_ready;
  // Only mid-word: last-bit cycles either reload or fall to IDLE.
  assign advance    = busy && !abort && !tc;

  // The register already holds the bit on sequence_out, so the next
  // bit is read one position in from the outgoing end.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    seq_d   = IDLE_LEVEL;
    bv_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (1'b1)
      accept: begin
        state_d = SHIFT;
        sreg_d  = load_data;
        seq_d   = LSB_FIRST ? load_data[0]
                            : load_data[WIDTH-1];
        bv_d    = 1'b1;
        cnt_clr = 1'b1;
      end
      advance: begin
        sreg_d  = LSB_FIRST ? (sreg_q >> 1)
                            : (sreg_q << 1);
        seq_d   = LSB_FIRST ? sreg_q[1]
                            : sreg_q[WIDTH-2];
        bv_d    = 1'b1;
        cnt_en  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      seq_q   <= IDLE_LEVEL;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      seq_q   <= seq_d;
      bv_q    <= bv_d;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = bv_q;

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 1011 sequence detector. It accepts WIDTH-bit pattern words over a valid/ready handshake and drives them onto the detector's serial input, one bit per clock. Words stream back-to-back with no gap bit when the next word is offered in time. A qualifying strobe and word-done pulse are provided for the LED/status logic.

Parameters:
WIDTH, 8, bits per pattern word (>=2)
LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first
IDLE_LEVEL, 0, value driven on sequence_out when no word is shifting

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_valid  in  1  producer offers load_data
load_data  in  WIDTH  pattern word
load_ready  out  1  stage can accept a word this cycle
abort  in  1  synchronous; kill the current word
sequence_out  out  1  serial bit to the detector's sequence_in
bit_valid  out  1  sequence_out carries a pattern bit this cycle
busy  out  1  a word is being shifted
done  out  1  one-cycle pulse while the last bit of a word is on sequence_out

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-low. While reset is low: state=IDLE, shift reg=0, bit count=0, sequence_out=IDLE_LEVEL, bit_valid=0, busy=0, done=0.
- States:
  - IDLE: no word shifting.
  - SHIFT: cnt runs 0..WIDTH-1.
- Output registration: sequence_out and bit_valid are registered.
- Combinational outputs:
  - busy = (state==SHIFT).
  - done = busy && cnt==WIDTH-1.
- load_ready = !abort && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)). This is combinational from state and abort, so load_ready reads 1 in IDLE.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
  - Accept at edge T: state=SHIFT, cnt=0, first bit on sequence_out and bit_valid=1 from T until edge T+1.
  - Bit k is presented in cycle k after acceptance.
  - Latency: load to first bit is 1 edge; word occupies exactly WIDTH cycles.
- Bit order: MSB first (load_data[WIDTH-1] first) when LSB_FIRST=0; otherwise load_data[0] first.
- Last bit (cnt==WIDTH-1):
  - If a word is accepted at the next edge: reload, cnt=0, and the new word's first bit follows with no gap; bit_valid stays 1.
  - Otherwise: go to IDLE, sequence_out=IDLE_LEVEL, bit_valid=0.
- load_valid while SHIFT and cnt<WIDTH-1: not accepted (load_ready=0). The producer must hold load_data/load_valid; the stage does not drop or latch it.
- abort: sampled at an edge while SHIFT, it moves the stage to IDLE, sequence_out=IDLE_LEVEL, bit_valid=0, with no done pulse. abort in IDLE has no effect. abort has priority over a coincident load (load_ready=0).
- Reset mid-word: the word is discarded immediately (async) and the stage restarts in IDLE after release.
- The stage never stalls mid-word. The detector samples every clock, so bit_valid=0 cycles feed IDLE_LEVEL.

Decomposition:
- Shared package (serializer_pkg):
  - state enum {IDLE, SHIFT}.
  - Count width localparam CNT_W = $clog2(WIDTH).
  - IDLE_LEVEL default constant.
- Sub-module: bit_counter, a CNT_W-bit counter with clear, enable and terminal-count flag (cnt==WIDTH-1). It is reused by the LED blink timers.
- The shift register and FSM stay in the top module.

Test Plan:
- Reset low 3 cycles, then release, with load_valid=0 → sequence_out=0, bit_valid=0, busy=0, load_ready=1, done=0 throughout.
- WIDTH=8, LSB_FIRST=0, load 8'b1011_0000 accepted at T → sequence_out 1,0,1,1,0,0,0,0 in cycles T..T+7. bit_valid=1 for exactly 8 cycles; done=1 only in cycle T+7. A chained detector asserts detector_out once, in cycle T+4.
- Back-to-back 8'hB0 then 8'hBB, second offered during the first word's last bit → 16 contiguous bit_valid cycles, no gap bit, done pulses in cycles 8 and 16. load_ready=1 only in IDLE and in the two last-bit cycles.
- LSB_FIRST=1, load 8'h0D → sequence 1,0,1,1,0,0,0,0, then IDLE.
- abort asserted while the 4th bit (cnt=3) is presented, with load_valid=1 → next cycle sequence_out=0, bit_valid=0, busy=0, no done, word not accepted that edge. The word is accepted on the following edge with load_ready=1.
- Reset pulled low at cnt=5, asynchronous to the clock edge → outputs go to reset values immediately. After release, the first new load starts at bit 0.
